calc_requester: RTL
===================

CALC_REQUESTER -- requirements
Module: calc_requester

Interface
REQ-001 The block SHALL have one parameter, TIMEOUT_CYCLES, default 255, giving the WAIT-state watchdog limit in cycles (range 1..255). It is used only when CALC_TIMEOUT_EN is defined.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  upstream request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_op  input  2  operation code.
REQ-008 req_a  input  4  operand A.
REQ-009 req_b  input  4  operand B.
REQ-010 GO  output  1  start strobe to small_calc.
REQ-011 OP  output  2  operation driven to small_calc.
REQ-012 in1  output  4  operand A driven to small_calc.
REQ-013 in2  output  4  operand B driven to small_calc.
REQ-014 doneFlag  input  1  completion level from small_calc.
REQ-015 calc_out  input  5  result from small_calc.
REQ-016 rsp_valid  output  1  response present.
REQ-017 rsp_ready  input  1  downstream accepts the response.
REQ-018 rsp_data  output  5  captured result.
REQ-019 rsp_err  output  1  response produced by timeout.
REQ-020 done_count  output  8  count of completed responses; wraps.
REQ-021 cur_state  output  3  state encoding, for debug.

Function
REQ-022 The block SHALL implement the states IDLE=0, ISSUE=1, WAIT=2 and RESP=3, plus DRAIN=4.
REQ-023 req_ready SHALL be 1 only when the state is IDLE and doneFlag is 0.
REQ-024 On req_valid && req_ready, the block SHALL register op/a/b into OP/in1/in2 and go to ISSUE.
REQ-025 In ISSUE, GO SHALL be 1 for exactly one cycle, then the state SHALL go to WAIT.
- A request accepted at cycle N produces GO at cycle N+1.
REQ-026 OP, in1 and in2 SHALL hold stable from ISSUE through the end of RESP.
- They change only on a new accept.
REQ-027 In WAIT, on the first cycle with doneFlag=1, the block SHALL capture calc_out into rsp_data, set rsp_err=0 and go to RESP.
- rsp_valid rises in the next cycle.
REQ-028 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_err SHALL be held until rsp_ready=1.
REQ-029 On the RESP handshake, the block SHALL increment done_count (modulo 256).
- It then goes to DRAIN if doneFlag=1, else to IDLE.
REQ-030 DRAIN SHALL wait for doneFlag=0 and then go to IDLE; no new GO is issued while doneFlag=1.
REQ-031 A doneFlag pulse seen in IDLE, ISSUE or DRAIN SHALL be ignored and SHALL NOT be captured.
REQ-032 The block SHALL sustain at most one outstanding operation.
- Back-to-back throughput is one request per 4 cycles plus the calculator latency.

Reset
REQ-033 Asserting rst SHALL immediately force the state to IDLE.
- Outputs forced to: GO=0, OP=0, in1=0, in2=0, rsp_valid=0, rsp_data=0, rsp_err=0, done_count=0, cur_state=0, req_ready=0.
REQ-034 After rst deasserts, req_ready SHALL follow REQ-023 from the first clock edge.
REQ-035 A reset mid-operation SHALL discard the in-flight request without producing a response.
- GO falls asynchronously.

Configuration
REQ-036 With CALC_TIMEOUT_EN defined, a WAIT-cycle counter SHALL clear on entry to WAIT.
- When it reaches TIMEOUT_CYCLES without doneFlag, the block goes to RESP with rsp_data=0 and rsp_err=1.
- If doneFlag and the timeout occur in the same cycle, doneFlag wins and rsp_err=0.
REQ-037 Without CALC_TIMEOUT_EN, no counter SHALL exist, rsp_err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Structure
REQ-038 Package calc_pkg SHALL hold the shared definitions.
- State encodings.
- OP codes: ADD=2'b00, SUB=2'b01, AND=2'b10, XOR=2'b11.
- Operand width 4 and result width 5, shared with small_calc.
REQ-039 The watchdog SHALL be a sub-module, calc_req_timer (clear, enable, expired), instantiated only under CALC_TIMEOUT_EN.

Verification
REQ-040 Basic ADD:
- Stimulus: req op=ADD, a=4'd9, b=4'd8; calculator model asserts doneFlag 3 cycles after GO with calc_out=5'd17.
- Required: GO for one cycle at accept+1; rsp_data=17, rsp_err=0; done_count=1.
REQ-041 Backpressure:
- Stimulus: rsp_ready held 0 for 10 cycles after rsp_valid.
- Required: rsp_data stable; req_ready=0 throughout; no second GO.
REQ-042 Sticky doneFlag:
- Stimulus: doneFlag held high 5 cycles past the handshake.
- Required: state enters DRAIN; next GO only after doneFlag=0.
REQ-043 Reset mid-WAIT:
- Stimulus: rst pulsed 2 cycles after GO.
- Required: all outputs 0 asynchronously; no rsp_valid; done_count=0.
REQ-044 Timeout (CALC_TIMEOUT_EN, TIMEOUT_CYCLES=4):
- Stimulus: no doneFlag.
- Required: rsp_valid with rsp_err=1, rsp_data=0 after 4 WAIT cycles.
- Same cycle doneFlag=1 with calc_out=5'd3: required rsp_err=0, rsp_data=3.
REQ-045 Wrap:
- Stimulus: 256 back-to-back SUB requests, a=4'd5, b=4'd2.
- Required: every rsp_data=3; done_count returns to 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calc_requester / small_calc pair: state and
// operation encodings plus the operand and result widths.
package calc_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_t;

endpackage

// File: rtl/calc_req_timer.sv
// WAIT-state watchdog for calc_requester: counts enabled cycles since the last
// clear and flags the cycle in which the TIMEOUT_CYCLES-th enabled cycle occurs.
module calc_req_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // Saturates at LIMIT so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/calc_requester.sv
// Request/response front end for small_calc: one operation in flight at a time.
// Define CALC_TIMEOUT_EN to add a WAIT-state watchdog that returns an error response.
module calc_requester
  import calc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [OPERAND_W-1:0] req_a,
  input  logic [OPERAND_W-1:0] req_b,
  output logic                GO,
  output logic [1:0]          OP,
  output logic [OPERAND_W-1:0] in1,
  output logic [OPERAND_W-1:0] in2,
  input  logic                doneFlag,
  input  logic [RESULT_W-1:0] calc_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RESULT_W-1:0] rsp_data,
  output logic                rsp_err,
  output logic [7:0]          done_count,
  output logic [2:0]          cur_state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("calc_requester: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t state, state_next;
  logic   accept;

  // Gating with rst keeps req_ready low while reset is held, not just after it.
  assign req_ready = (state == ST_IDLE) && !doneFlag && !rst;
  assign accept    = req_valid && req_ready;
  assign GO        = (state == ST_ISSUE);
  assign rsp_valid = (state == ST_RESP);
  assign cur_state = state;

`ifdef CALC_TIMEOUT_EN
  logic timed_out;

  calc_req_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .expired(timed_out)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (doneFlag) begin
          state_next = ST_RESP;
        end
`ifdef CALC_TIMEOUT_EN
        else if (timed_out) begin
          state_next = ST_RESP;
        end
`endif
      end
      // A still-high doneFlag belongs to the finished operation; drain it first.
      ST_RESP:  if (rsp_ready) state_next = doneFlag ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!doneFlag) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OP         <= '0;
      in1        <= '0;
      in2        <= '0;
      rsp_data   <= '0;
      done_count <= '0;
    end else begin
      if (accept) begin
        OP  <= req_op;
        in1 <= req_a;
        in2 <= req_b;
      end
      if (state == ST_WAIT) begin
        if (doneFlag) begin
          rsp_data <= calc_out;
        end
`ifdef CALC_TIMEOUT_EN
        else if (timed_out) begin
          rsp_data <= '0;
        end
`endif
      end
      if ((state == ST_RESP) && rsp_ready) begin
        done_count <= done_count + 8'd1;
      end
    end
  end

`ifdef CALC_TIMEOUT_EN
  // A real completion in the expiry cycle takes priority over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (doneFlag) begin
        rsp_err <= 1'b0;
      end else if (timed_out) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
